// File: rtl/wb_sram_bridge.sv
// Wishbone classic slave bridging onto a 1RW OpenRAM macro, with optional zero-fill after reset.
// Latency: request sampled at edge N, ack high between edges N+1 and N+2; one transfer per 3 cycles.
// Backpressure: requests stall (no ack) during the post-reset clear; off-window requests are ignored.
module wb_sram_bridge #(
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK      = 32'hFFFF_FC00,
  parameter int          ADDR_WIDTH     = 8,
  parameter int          DATA_WIDTH     = 32,
  parameter int          CLEAR_ON_RESET = 1
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_we_i,
  input  logic [DATA_WIDTH/8-1:0] wbs_sel_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
  output logic                    wbs_ack_o,
  output logic [DATA_WIDTH-1:0]   wbs_dat_o,
  output logic                    sram_clk0,
  output logic                    sram_csb0,
  output logic                    sram_web0,
  output logic [DATA_WIDTH/8-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0]   sram_addr0,
  output logic [DATA_WIDTH-1:0]   sram_din0,
  input  logic [DATA_WIDTH-1:0]   sram_dout0,
  output logic                    init_done
);

  localparam int NUM_WMASKS = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;
  localparam logic [1:0] ST_ACK   = 2'd3;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  req_we;
  logic                  bus_req;
  logic                  hit;

  assign bus_req   = wbs_cyc_i & wbs_stb_i;
  assign hit       = bus_req & ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);
  // The macro shares our clock so it latches pins on the same edge the FSM moves.
  assign sram_clk0 = wb_clk_i;

  // Macro pins are decoded straight from state and bus inputs; reset forces deselect.
  always_comb begin
    sram_csb0   = 1'b1;
    sram_web0   = 1'b1;
    sram_wmask0 = '0;
    sram_addr0  = '0;
    sram_din0   = '0;
    case (state)
      ST_CLEAR: begin
        sram_csb0   = 1'b0;
        sram_web0   = 1'b0;
        sram_wmask0 = {NUM_WMASKS{1'b1}};
        sram_addr0  = clr_cnt;
      end
      ST_IDLE: begin
        if (hit) begin
          sram_csb0   = 1'b0;
          sram_web0   = ~wbs_we_i;
          sram_wmask0 = wbs_we_i ? wbs_sel_i : '0;
          sram_addr0  = wbs_adr_i[ADDR_WIDTH+1:2];
          sram_din0   = wbs_dat_i;
        end
      end
      default: begin
      end
    endcase
    if (wb_rst_i) begin
      sram_csb0 = 1'b1;
    end
  end

  // Bridge FSM: clear sweep, request issue, response/abort, ack turnaround.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      clr_cnt   <= '0;
      req_we    <= 1'b0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      init_done <= 1'b0;
    end else begin
      wbs_ack_o <= 1'b0;
      case (state)
        ST_CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST_ADDR) begin
            state     <= ST_IDLE;
            init_done <= 1'b1;
          end
        end
        ST_IDLE: begin
          // Without a clear sweep this is the first post-reset state, so flag ready here too.
          init_done <= 1'b1;
          if (hit) begin
            req_we <= wbs_we_i;
            state  <= ST_RESP;
          end
        end
        ST_RESP: begin
          // A master that drops cyc/stb here aborts; an issued write still lands in the macro.
          if (bus_req) begin
            wbs_ack_o <= 1'b1;
            if (!req_we) begin
              wbs_dat_o <= sram_dout0;
            end
            state <= ST_ACK;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
